binsearch_lb: RTL and testbench

Parametrised lower-bound binary search over an external synchronous-read sorted memory. It generalises the fixed 32×8 exact-match searcher in three ways: configurable data width, depth and read latency; first-occurrence results when keys are duplicated; and an insertion index when the key is absent. It sits between the lookup controller and a single-port ROM/RAM, which it drives through a read-only address/data port.

---
 rtl/binsearch_lb_pkg.sv | 19 +
 rtl/binsearch_lb_if.sv | 25 ++
 rtl/binsearch_lb_cmp.sv | 19 +
 rtl/binsearch_lb.sv | 124 ++++++++++++
 tb/tb_binsearch_lb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/binsearch_lb_pkg.sv
// Shared types for the lower-bound binary searcher: FSM state enum and index-width helper.
package binsearch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } bs_state_t;

  // lo + hi can reach 2^(ADDR_W+1), so mid arithmetic carries two spare bits.
  localparam int unsigned IDX_EXTRA = 2;

  function automatic int unsigned idx_w(input int unsigned addr_w);
    return addr_w + IDX_EXTRA;
  endfunction

endpackage

// File: rtl/binsearch_lb_if.sv
// Request/result and memory read-port bundle for binsearch_lb.
interface binsearch_lb_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);

  logic              Start;
  logic [DATA_W-1:0] a;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [ADDR_W:0]   Loc;
  logic              Found;
  logic              Done;

  modport master (
    output Start, a, mem_rd_data,
    input  mem_addr, Loc, Found, Done
  );

  modport slave (
    input  Start, a, mem_rd_data,
    output mem_addr, Loc, Found, Done
  );

endinterface

// File: rtl/binsearch_lb_cmp.sv
// Key/data comparator; BINSEARCH_SIGNED_EN selects two's-complement ordering.
module binsearch_cmp #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              lt,
  output logic              eq
);

`ifdef BINSEARCH_SIGNED_EN
  always_comb lt = $signed(x) < $signed(y);
`else
  always_comb lt = x < y;
`endif

  always_comb eq = (x == y);

endmodule

// File: rtl/binsearch_lb.sv
// Lower-bound binary search over an external RD_LAT-cycle synchronous memory.
// Build option: BINSEARCH_SIGNED_EN (signed key/data ordering, handled in binsearch_cmp).
module binsearch_lb
  import binsearch_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  binsearch_lb_if.slave  bus
);

  localparam int unsigned IW   = idx_w(ADDR_W);
  localparam int unsigned WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  bs_state_t         state, state_n;
  logic [DATA_W-1:0] key, key_n;
  logic [IW-1:0]     lo, lo_n, hi, hi_n, mid, mid_r, mid_n;
  logic              hit, hit_n, found, found_n;
  logic [WC_W-1:0]   wcnt, wcnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W:0]   loc, loc_n;
  logic              lt, eq;

  binsearch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .x  (bus.mem_rd_data),
    .y  (key),
    .lt (lt),
    .eq (eq)
  );

  always_comb mid = (lo + hi) >> 1;

  always_comb begin
    state_n = state;
    key_n   = key;
    lo_n    = lo;
    hi_n    = hi;
    hit_n   = hit;
    mid_n   = mid_r;
    wcnt_n  = wcnt;
    addr_n  = addr;
    loc_n   = loc;
    found_n = found;
    unique case (state)
      S_IDLE: begin
        if (bus.Start) begin
          key_n   = bus.a;
          lo_n    = '0;
          hi_n    = IW'(DEPTH);
          hit_n   = 1'b0;
          found_n = 1'b0;
          loc_n   = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        addr_n  = mid[ADDR_W-1:0];
        mid_n   = mid;
        wcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == WC_W'(RD_LAT - 1)) state_n = S_COMPARE;
        else                           wcnt_n  = wcnt + 1'b1;
      end
      S_COMPARE: begin
        if (lt) begin
          lo_n = mid_r + 1'b1;
        end else begin
          hi_n = mid_r;
          if (eq) hit_n = 1'b1;
        end
        // Any probe that matched implies the final lower bound is a match.
        if (lo_n >= hi_n) begin
          loc_n   = lo_n[ADDR_W:0];
          found_n = hit_n;
          state_n = S_DONE;
        end else begin
          state_n = S_ISSUE;
        end
      end
      S_DONE: begin
        if (!bus.Start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= S_IDLE;
      key   <= '0;
      lo    <= '0;
      hi    <= '0;
      hit   <= 1'b0;
      mid_r <= '0;
      wcnt  <= '0;
      addr  <= '0;
      loc   <= '0;
      found <= 1'b0;
    end else begin
      state <= state_n;
      key   <= key_n;
      lo    <= lo_n;
      hi    <= hi_n;
      hit   <= hit_n;
      mid_r <= mid_n;
      wcnt  <= wcnt_n;
      addr  <= addr_n;
      loc   <= loc_n;
      found <= found_n;
    end
  end

  assign bus.mem_addr = addr;
  assign bus.Loc      = loc;
  assign bus.Found    = found;
  assign bus.Done     = (state == S_DONE);

endmodule

// File: tb/tb_binsearch_lb.sv
// Bench for binsearch_lb: two configurations (32/RD_LAT 2 and 20/RD_LAT 1) against a linear-scan model.
module tb_binsearch_lb;

  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  binsearch_lb_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
  binsearch_lb_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();

  binsearch_lb #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(2)) dut0 (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus0)
  );

  binsearch_lb #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RD_LAT(1)) dut1 (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus1)
  );

  // Behavioural memories with 2-cycle and 1-cycle read latency.
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
  logic [7:0] pipe0 [2];
  logic [7:0] pipe1;

  always @(posedge CLOCK_50) begin
    pipe0[0] <= mem0[bus0.mem_addr];
    pipe0[1] <= pipe0[0];
    pipe1    <= mem1[bus1.mem_addr];
  end
  assign bus0.mem_rd_data = pipe0[1];
  assign bus1.mem_rd_data = pipe1;

`ifdef BINSEARCH_SIGNED_EN
  localparam logic [7:0] BASE = 8'hC0;
  function automatic bit key_lt(input logic [7:0] x, input logic [7:0] y);
    return $signed(x) < $signed(y);
  endfunction
`else
  localparam logic [7:0] BASE = 8'd2;
  function automatic bit key_lt(input logic [7:0] x, input logic [7:0] y);
    return x < y;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned depth_of(input int inst);
    return (inst != 0) ? 20 : 32;
  endfunction

  function automatic logic [7:0] mem_rd(input int inst, input int unsigned i);
    return (inst != 0) ? mem1[i] : mem0[i];
  endfunction

  // Lower bound by linear scan over the sorted array.
  function automatic int unsigned ref_loc(input int inst, input logic [7:0] k);
    for (int unsigned i = 0; i < depth_of(inst); i++)
      if (!key_lt(mem_rd(inst, i), k)) return i;
    return depth_of(inst);
  endfunction

  function automatic logic [31:0] get_loc(input int inst);
    return (inst != 0) ? 32'(bus1.Loc) : 32'(bus0.Loc);
  endfunction
  function automatic logic [31:0] get_found(input int inst);
    return (inst != 0) ? 32'(bus1.Found) : 32'(bus0.Found);
  endfunction
  function automatic logic [31:0] get_done(input int inst);
    return (inst != 0) ? 32'(bus1.Done) : 32'(bus0.Done);
  endfunction
  function automatic logic [31:0] get_addr(input int inst);
    return (inst != 0) ? 32'(bus1.mem_addr) : 32'(bus0.mem_addr);
  endfunction

  task automatic set_in(input int inst, input logic s, input logic [7:0] k);
    if (inst != 0) begin bus1.Start = s; bus1.a = k; end
    else           begin bus0.Start = s; bus0.a = k; end
  endtask

  // Launch from IDLE, scramble the key after capture, wait (bounded) for Done.
  task automatic run(input int inst, input logic [7:0] k, input bit hold, output int cyc);
    set_in(inst, 1'b1, k);
    @(posedge CLOCK_50); #1;
    set_in(inst, hold, k ^ 8'h5A);
    cyc = 0;
    while (cyc < 200 && get_done(inst) !== 32'd1) begin
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    chk("done_seen", get_done(inst), 32'd1);
  endtask

  task automatic check_res(input int inst, input logic [7:0] k, input string tag, input int cyc);
    int unsigned el;
    logic        ef;
    int          bound;
    el = ref_loc(inst, k);
    ef = (el < depth_of(inst)) && (mem_rd(inst, el) == k);
    bound = (inst != 0) ? 5 * 3 : 6 * 4;
    chk({tag, "_loc"}, get_loc(inst), el);
    chk({tag, "_found"}, get_found(inst), 32'(ef));
    chk({tag, "_latency_le_bound"}, 32'(cyc <= bound), 32'd1);
  endtask

  task automatic release_start(input int inst);
    set_in(inst, 1'b0, 8'h00);
    @(posedge CLOCK_50); #1;
    chk("done_drops", get_done(inst), 32'd0);
  endtask

  task automatic search(input int inst, input logic [7:0] k, input string tag, output int cyc);
    run(inst, k, 1'b0, cyc);
    check_res(inst, k, tag, cyc);
    release_start(inst);
  endtask

  task automatic fill_linear();
    for (int unsigned i = 0; i < 32; i++) begin
      mem0[i] = BASE + 8'(4 * i);
      mem1[i] = BASE + 8'(4 * i);
    end
  endtask

  task automatic fill_random();
    logic [7:0] v0, v1;
    v0 = BASE + 8'($urandom_range(0, 3));
    v1 = BASE + 8'($urandom_range(0, 3));
    for (int unsigned i = 0; i < 32; i++) begin
      mem0[i] = v0;
      mem1[i] = v1;
      v0 = v0 + 8'($urandom_range(0, 3));
      v1 = v1 + 8'($urandom_range(0, 3));
    end
  endtask

  always @(negedge CLOCK_50)
    if (mon_en) chk("addr1_lt_depth", 32'(bus1.mem_addr < 5'd20), 32'd1);

  initial begin : main
    int cyc;
    logic [7:0] dkeys [5];
    int unsigned dloc [5];
    logic        dfnd [5];
    logic [7:0] k;

`ifdef BINSEARCH_SIGNED_EN
    dkeys = '{8'hC0, 8'h3C, 8'hC1, 8'h7F, 8'h80};
    dloc  = '{0, 31, 1, 32, 0};
    dfnd  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    dkeys = '{8'd2, 8'd126, 8'd3, 8'd200, 8'd0};
    dloc  = '{0, 31, 1, 32, 0};
    dfnd  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    fill_linear();
    Reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      chk("rst_loc", get_loc(inst), 32'd0);
      chk("rst_found", get_found(inst), 32'd0);
      chk("rst_done", get_done(inst), 32'd0);
      chk("rst_addr", get_addr(inst), 32'd0);
    end
    Reset = 1'b0;
    mon_en = 1'b1;

    // Directed keys on the linear memory, with fixed expected results.
    for (int i = 0; i < 5; i++) begin
      run(0, dkeys[i], 1'b0, cyc);
      chk("dir_loc", get_loc(0), dloc[i]);
      chk("dir_found", get_found(0), 32'(dfnd[i]));
      if (i == 0) chk("first_hit_latency", cyc, 32'd24);
      release_start(0);
    end

    // Duplicates: first occurrence wins.
    for (int unsigned i = 10; i <= 13; i++) mem0[i] = BASE + 8'd40;
    run(0, BASE + 8'd40, 1'b0, cyc);
    chk("dup_loc", get_loc(0), 32'd10);
    chk("dup_found", get_found(0), 32'd1);
    release_start(0);
    fill_linear();

    // Non-power-of-two depth, last element.
    run(1, mem1[19], 1'b0, cyc);
    chk("d20_loc", get_loc(1), 32'd19);
    chk("d20_found", get_found(1), 32'd1);
    release_start(1);

    // Start held through DONE: results and Done must persist, no retrigger.
    k = BASE + 8'd20;
    run(0, k, 1'b1, cyc);
    check_res(0, k, "hold", cyc);
    repeat (10) begin
      @(posedge CLOCK_50); #1;
      chk("hold_done", get_done(0), 32'd1);
      chk("hold_loc", get_loc(0), 32'd5);
      chk("hold_found", get_found(0), 32'd1);
    end
    release_start(0);

    // Reset in the third probe, then a clean search.
    set_in(0, 1'b1, BASE + 8'd100);
    @(posedge CLOCK_50); #1;
    set_in(0, 1'b0, 8'h00);
    repeat (10) @(posedge CLOCK_50);
    #1;
    Reset = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("midrst_loc", get_loc(0), 32'd0);
    chk("midrst_found", get_found(0), 32'd0);
    chk("midrst_done", get_done(0), 32'd0);
    chk("midrst_addr", get_addr(0), 32'd0);
    Reset = 1'b0;
    search(0, BASE + 8'd100, "post_rst", cyc);

    // Randomized sorted memories with duplicates; keys present or arbitrary.
    for (int n = 0; n < 40; n++) begin
      fill_random();
      for (int inst = 0; inst < 2; inst++) begin
        if ($urandom_range(0, 1) != 0)
          k = mem_rd(inst, $urandom_range(0, depth_of(inst) - 1));
        else
          k = 8'($urandom);
        search(inst, k, "rand", cyc);
      end
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
